// File: rtl/sprite_pkg.sv
// Shared types and helpers for the player sprite controller.
package sprite_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    BOOM   = 2'd1,
    INVINC = 2'd2,
    DEAD   = 2'd3
  } state_t;

  // Bit positions inside the 4-bit direction bus
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  // Default colour key for transparent sprite pixels
  localparam logic [11:0] TRANSP_DEF = 12'hFFF;

  // One clamped step on a single axis. Done in 11 bits so that neither the
  // decrement nor the increment can wrap. Opposing bits cancel.
  function automatic logic [9:0] step_axis(input logic [9:0]  pos,
                                           input logic        dec,
                                           input logic        inc,
                                           input logic [10:0] step,
                                           input logic [10:0] maxv);
    logic [10:0] p;
    p = {1'b0, pos};
    if (dec && !inc)      p = (p < step) ? 11'd0 : (p - step);
    else if (inc && !dec) p = ((p + step) > maxv) ? maxv : (p + step);
    return p[9:0];
  endfunction

endpackage

// File: rtl/sprite_pixel_pipe.sv
// Per-pixel path: box test and ROM address in cycle N, then colour select
// and opacity in cycle N+1 once the ROM data has arrived.
module sprite_pixel_pipe
  import sprite_pkg::*;
#(
  parameter int          SPR_W  = 50,
  parameter int          SPR_H  = 50,
  parameter int          AW     = 12,
  parameter logic [11:0] TRANSP = TRANSP_DEF
)(
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic [9:0]    p_x,
  input  logic [9:0]    p_y,
  input  state_t        state,
  input  logic          blink,
  input  logic [11:0]   plane_rgb,
  input  logic [11:0]   boom_rgb,
  output logic [AW-1:0] spr_addr,
  output logic [11:0]   rgb,
  output logic          EN
);

  localparam logic [AW-1:0] SPR_W_A = AW'(SPR_W);

  logic [10:0]   w_x_end, w_y_end;
  logic          w_in_box;
  logic [9:0]    w_dx, w_dy;
  logic [AW-1:0] w_addr;
  logic [11:0]   w_rgb_sel;

  logic          r_in_box_d;
  state_t        r_state_d;
  logic          r_blink_d;

  // Box test in 11 bits so p_x+SPR_W near the screen edge cannot wrap
  assign w_x_end  = {1'b0, p_x} + 11'(SPR_W);
  assign w_y_end  = {1'b0, p_y} + 11'(SPR_H);
  assign w_in_box = (x >= p_x) && ({1'b0, x} < w_x_end) &&
                    (y >= p_y) && ({1'b0, y} < w_y_end);

  assign w_dx     = x - p_x;
  assign w_dy     = y - p_y;
  assign w_addr   = AW'(w_dy) * SPR_W_A + AW'(w_dx);
  assign spr_addr = w_in_box ? w_addr : '0;

  // Align box hit and sprite state with the ROM's one-cycle read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_box_d <= 1'b0;
      r_state_d  <= ALIVE;
      r_blink_d  <= 1'b0;
    end else begin
      r_in_box_d <= w_in_box;
      r_state_d  <= state;
      r_blink_d  <= blink;
    end
  end

  assign w_rgb_sel = (r_state_d == BOOM) ? boom_rgb : plane_rgb;
  assign rgb       = r_in_box_d ? w_rgb_sel : 12'h000;
  // Invincibility blinks by suppressing every other 8-tick window
  assign EN        = r_in_box_d && (w_rgb_sel != TRANSP) && (r_state_d != DEAD) &&
                     !((r_state_d == INVINC) && r_blink_d);

endmodule

// File: rtl/player_sprite_ctrl.sv
// Player sprite controller: position, clamped motion, lives and the
// hit -> explosion -> invincible respawn sequence, plus the pixel path.
module player_sprite_ctrl
  import sprite_pkg::*;
#(
  parameter int          SCR_W      = 640,
  parameter int          SCR_H      = 480,
  parameter int          SPR_W      = 50,
  parameter int          SPR_H      = 50,
  parameter int          STEP       = 1,
  parameter int          LIVES      = 3,
  parameter int          BOOM_TICKS = 15,
  parameter int          INV_TICKS  = 120,
  parameter logic [11:0] TRANSP     = TRANSP_DEF,
  localparam int         AW         = $clog2(SPR_W*SPR_H),
  localparam int         LW         = $clog2(LIVES+1)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          move_tick,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic [3:0]    direction,
  input  logic          hit,
  output logic [AW-1:0] spr_addr,
  input  logic [11:0]   plane_rgb,
  input  logic [11:0]   boom_rgb,
  output logic [9:0]    p_x,
  output logic [9:0]    p_y,
  output logic [11:0]   rgb,
  output logic          EN,
  output logic          alive,
  output logic [LW-1:0] lives_left,
  output logic          game_over
);

  localparam int          CMAX    = (BOOM_TICKS > INV_TICKS) ? BOOM_TICKS : INV_TICKS;
  localparam int          CW_RAW  = $clog2(CMAX + 1);
  // At least 4 bits so bit 3 exists for the blink
  localparam int          CW      = (CW_RAW < 4) ? 4 : CW_RAW;
  localparam logic [CW-1:0] BOOM_END = CW'(BOOM_TICKS - 1);
  localparam logic [CW-1:0] INV_END  = CW'(INV_TICKS - 1);
  localparam logic [10:0] MAX_X   = 11'(SCR_W - SPR_W);
  localparam logic [10:0] MAX_Y   = 11'(SCR_H - SPR_H);
  localparam logic [10:0] STEP_L  = 11'(STEP);
  localparam logic [9:0]  SPAWN_X = 10'((SCR_W - SPR_W) / 2);
  localparam logic [9:0]  SPAWN_Y = 10'(SCR_H - SPR_H);

  state_t        r_state, w_state;
  logic [9:0]    r_px, r_py, w_px, w_py;
  logic [LW-1:0] r_lives, w_lives;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [9:0]    w_mv_x, w_mv_y;

  assign w_mv_x = step_axis(r_px, direction[DIR_LEFT], direction[DIR_RIGHT], STEP_L, MAX_X);
  assign w_mv_y = step_axis(r_py, direction[DIR_UP],   direction[DIR_DOWN],  STEP_L, MAX_Y);

  // State, position, lives and tick counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ALIVE;
      r_px    <= SPAWN_X;
      r_py    <= SPAWN_Y;
      r_lives <= LW'(LIVES);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_px    <= w_px;
      r_py    <= w_py;
      r_lives <= w_lives;
      r_cnt   <= w_cnt;
    end
  end

  // Next-state logic; a hit takes priority over a same-cycle move tick
  always_comb begin
    w_state = r_state;
    w_px    = r_px;
    w_py    = r_py;
    w_lives = r_lives;
    w_cnt   = r_cnt;
    case (r_state)
      ALIVE: begin
        if (hit) begin
          w_state = BOOM;
          w_lives = r_lives - LW'(1);
          w_cnt   = '0;
        end else if (move_tick) begin
          w_px = w_mv_x;
          w_py = w_mv_y;
        end
      end
      BOOM: begin
        if (move_tick) begin
          if (r_cnt == BOOM_END) begin
            w_cnt = '0;
            if (r_lives == '0) begin
              w_state = DEAD;
            end else begin
              w_state = INVINC;
              w_px    = SPAWN_X;
              w_py    = SPAWN_Y;
            end
          end else begin
            w_cnt = r_cnt + CW'(1);
          end
        end
      end
      INVINC: begin
        if (move_tick) begin
          w_px = w_mv_x;
          w_py = w_mv_y;
          if (r_cnt == INV_END) begin
            w_state = ALIVE;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + CW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign p_x        = r_px;
  assign p_y        = r_py;
  assign lives_left = r_lives;
  assign alive      = (r_state == ALIVE) || (r_state == INVINC);
  assign game_over  = (r_state == DEAD);

  sprite_pixel_pipe #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .AW    (AW),
    .TRANSP(TRANSP)
  ) u_pix (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .p_x      (r_px),
    .p_y      (r_py),
    .state    (r_state),
    .blink    (r_cnt[3]),
    .plane_rgb(plane_rgb),
    .boom_rgb (boom_rgb),
    .spr_addr (spr_addr),
    .rgb      (rgb),
    .EN       (EN)
  );

endmodule

// File: tb/tb_player_sprite_ctrl.sv
// Directed bench for player_sprite_ctrl with a one-cycle-latency ROM model.
module tb_player_sprite_ctrl;

  logic        clk, rst, move_tick, hit;
  logic [9:0]  x, y, p_x, p_y;
  logic [3:0]  direction;
  logic [11:0] spr_addr;
  logic [11:0] plane_rgb, boom_rgb, rgb;
  logic        EN, alive, game_over;
  logic [1:0]  lives_left;

  int n_cmp = 0;
  int n_bad = 0;

  player_sprite_ctrl dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .x(x), .y(y),
    .direction(direction), .hit(hit), .spr_addr(spr_addr),
    .plane_rgb(plane_rgb), .boom_rgb(boom_rgb), .p_x(p_x), .p_y(p_y),
    .rgb(rgb), .EN(EN), .alive(alive), .lives_left(lives_left),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: address 102 holds the transparent key, everything else is opaque
  always @(posedge clk) begin
    plane_rgb <= (spr_addr == 12'd102) ? 12'hFFF : 12'h0C3;
    boom_rgb  <= (spr_addr == 12'd102) ? 12'hFFF : 12'hF80;
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      move_tick = 1'b1; cycle();
    end
    move_tick = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1; cycle(); hit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; hit = 1'b0; move_tick = 1'b0; direction = 4'b0000;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    x = 10'd0; y = 10'd0;
    do_reset();
    n_cmp++; if (p_x !== 10'd295) begin n_bad++; $display("FAIL rst_px got %0d want 295", p_x); end
    n_cmp++; if (p_y !== 10'd430) begin n_bad++; $display("FAIL rst_py got %0d want 430", p_y); end
    n_cmp++; if (lives_left !== 2'd3) begin n_bad++; $display("FAIL rst_lives got %0d want 3", lives_left); end
    n_cmp++; if (alive !== 1'b1 || game_over !== 1'b0) begin n_bad++; $display("FAIL rst_flags alive=%b go=%b want 1/0", alive, game_over); end
    n_cmp++; if (EN !== 1'b0 || rgb !== 12'h000) begin n_bad++; $display("FAIL rst_pix EN=%b rgb=%h want 0/000", EN, rgb); end
    n_cmp++; if (spr_addr !== 12'd0) begin n_bad++; $display("FAIL rst_addr got %0d want 0", spr_addr); end
  endtask

  task automatic test_move_left();
    int exp_x;
    direction = 4'b0100;
    for (int i = 1; i <= 300; i++) begin
      ticks(1);
      exp_x = (295 - i > 0) ? 295 - i : 0;
      n_cmp++; if (p_x !== 10'(exp_x)) begin n_bad++; $display("FAIL left_px tick %0d got %0d want %0d", i, p_x, exp_x); end
    end
    n_cmp++; if (p_y !== 10'd430) begin n_bad++; $display("FAIL left_py got %0d want 430", p_y); end
  endtask

  task automatic test_move_right_up();
    direction = 4'b1000; ticks(589);
    n_cmp++; if (p_x !== 10'd589) begin n_bad++; $display("FAIL right_px got %0d want 589", p_x); end
    direction = 4'b1001; ticks(1);
    n_cmp++; if (p_x !== 10'd590 || p_y !== 10'd429) begin n_bad++; $display("FAIL ru1 got %0d,%0d want 590,429", p_x, p_y); end
    ticks(1);
    n_cmp++; if (p_x !== 10'd590 || p_y !== 10'd428) begin n_bad++; $display("FAIL ru2 got %0d,%0d want 590,428", p_x, p_y); end
    cycle(); // no tick: no motion
    n_cmp++; if (p_x !== 10'd590 || p_y !== 10'd428) begin n_bad++; $display("FAIL notick got %0d,%0d want 590,428", p_x, p_y); end
    direction = 4'b0001; ticks(433);
    n_cmp++; if (p_y !== 10'd0) begin n_bad++; $display("FAIL up_clamp got %0d want 0", p_y); end
  endtask

  task automatic test_opposing();
    direction = 4'b0011; ticks(3);
    n_cmp++; if (p_y !== 10'd0) begin n_bad++; $display("FAIL ud_top got %0d want 0", p_y); end
    direction = 4'b0010; ticks(5);
    direction = 4'b0011; ticks(3);
    n_cmp++; if (p_y !== 10'd5) begin n_bad++; $display("FAIL ud_mid got %0d want 5", p_y); end
    direction = 4'b0100; ticks(10);
    direction = 4'b1100; ticks(3);
    n_cmp++; if (p_x !== 10'd580) begin n_bad++; $display("FAIL lr_mid got %0d want 580", p_x); end
    direction = 4'b1111; ticks(3);
    n_cmp++; if (p_x !== 10'd580 || p_y !== 10'd5) begin n_bad++; $display("FAIL all4 got %0d,%0d want 580,5", p_x, p_y); end
  endtask

  task automatic test_hit();
    do_reset();
    direction = 4'b0100; ticks(5);
    hit = 1'b1; move_tick = 1'b1; cycle(); hit = 1'b0; move_tick = 1'b0;
    n_cmp++; if (alive !== 1'b0 || lives_left !== 2'd2 || p_x !== 10'd290) begin n_bad++; $display("FAIL hit_tick alive=%b lives=%0d px=%0d want 0/2/290", alive, lives_left, p_x); end
    pulse_hit();
    n_cmp++; if (lives_left !== 2'd2) begin n_bad++; $display("FAIL boom_hit lives=%0d want 2", lives_left); end
    ticks(14);
    n_cmp++; if (alive !== 1'b0 || p_x !== 10'd290) begin n_bad++; $display("FAIL boom14 alive=%b px=%0d want 0/290", alive, p_x); end
    ticks(1);
    n_cmp++; if (alive !== 1'b1 || p_x !== 10'd295 || p_y !== 10'd430) begin n_bad++; $display("FAIL spawn alive=%b pos=%0d,%0d want 1/295,430", alive, p_x, p_y); end
    pulse_hit();
    n_cmp++; if (lives_left !== 2'd2 || alive !== 1'b1) begin n_bad++; $display("FAIL inv_hit lives=%0d alive=%b want 2/1", lives_left, alive); end
    ticks(1);
    n_cmp++; if (p_x !== 10'd294) begin n_bad++; $display("FAIL inv_move px=%0d want 294", p_x); end
    ticks(118);
    pulse_hit();
    n_cmp++; if (lives_left !== 2'd2) begin n_bad++; $display("FAIL inv_last lives=%0d want 2", lives_left); end
    ticks(1);
    n_cmp++; if (p_x !== 10'd175 || alive !== 1'b1) begin n_bad++; $display("FAIL inv_end px=%0d alive=%b want 175/1", p_x, alive); end
    pulse_hit();
    n_cmp++; if (lives_left !== 2'd1 || alive !== 1'b0) begin n_bad++; $display("FAIL alive_hit lives=%0d alive=%b want 1/0", lives_left, alive); end
  endtask

  task automatic test_dead();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pulse_hit(); ticks(14);
      if (k < 2) ticks(121);
    end
    n_cmp++; if (lives_left !== 2'd0 || alive !== 1'b0 || game_over !== 1'b0) begin n_bad++; $display("FAIL last_boom lives=%0d alive=%b go=%b want 0/0/0", lives_left, alive, game_over); end
    ticks(1);
    n_cmp++; if (game_over !== 1'b1 || alive !== 1'b0) begin n_bad++; $display("FAIL dead go=%b alive=%b want 1/0", game_over, alive); end
    x = 10'd296; y = 10'd432;
    cycle(); cycle();
    n_cmp++; if (EN !== 1'b0) begin n_bad++; $display("FAIL dead_en got %b want 0", EN); end
    direction = 4'b0100; ticks(5); pulse_hit();
    n_cmp++; if (p_x !== 10'd295 || lives_left !== 2'd0 || game_over !== 1'b1) begin n_bad++; $display("FAIL frozen px=%0d lives=%0d go=%b want 295/0/1", p_x, lives_left, game_over); end
    do_reset();
    n_cmp++; if (lives_left !== 2'd3 || game_over !== 1'b0 || alive !== 1'b1) begin n_bad++; $display("FAIL dead_rst lives=%0d go=%b alive=%b want 3/0/1", lives_left, game_over, alive); end
    pulse_hit(); do_reset();
    n_cmp++; if (lives_left !== 2'd3 || alive !== 1'b1) begin n_bad++; $display("FAIL boom_rst lives=%0d alive=%b want 3/1", lives_left, alive); end
  endtask

  task automatic test_pixel();
    do_reset();
    x = 10'd296; y = 10'd432; #1;
    n_cmp++; if (spr_addr !== 12'd101) begin n_bad++; $display("FAIL addr101 got %0d want 101", spr_addr); end
    cycle();
    n_cmp++; if (EN !== 1'b1 || rgb !== 12'h0C3) begin n_bad++; $display("FAIL pix101 EN=%b rgb=%h want 1/0c3", EN, rgb); end
    x = 10'd297; #1;
    n_cmp++; if (spr_addr !== 12'd102) begin n_bad++; $display("FAIL addr102 got %0d want 102", spr_addr); end
    cycle();
    n_cmp++; if (EN !== 1'b0 || rgb !== 12'hFFF) begin n_bad++; $display("FAIL transp EN=%b rgb=%h want 0/fff", EN, rgb); end
    x = 10'd344; y = 10'd479; #1;
    n_cmp++; if (spr_addr !== 12'd2499) begin n_bad++; $display("FAIL addr_last got %0d want 2499", spr_addr); end
    cycle();
    n_cmp++; if (EN !== 1'b1) begin n_bad++; $display("FAIL pix_last EN=%b want 1", EN); end
    x = 10'd345; #1;
    n_cmp++; if (spr_addr !== 12'd0) begin n_bad++; $display("FAIL addr_out got %0d want 0", spr_addr); end
    cycle();
    n_cmp++; if (EN !== 1'b0 || rgb !== 12'h000) begin n_bad++; $display("FAIL pix_out EN=%b rgb=%h want 0/000", EN, rgb); end
    x = 10'd296; y = 10'd429; cycle();
    n_cmp++; if (EN !== 1'b0) begin n_bad++; $display("FAIL pix_above EN=%b want 0", EN); end
    y = 10'd432;
    pulse_hit(); cycle();
    n_cmp++; if (EN !== 1'b1 || rgb !== 12'hF80) begin n_bad++; $display("FAIL boom_pix EN=%b rgb=%h want 1/f80", EN, rgb); end
    ticks(15); cycle();
    n_cmp++; if (EN !== 1'b1 || rgb !== 12'h0C3) begin n_bad++; $display("FAIL inv_on EN=%b rgb=%h want 1/0c3", EN, rgb); end
    ticks(8); cycle();
    n_cmp++; if (EN !== 1'b0) begin n_bad++; $display("FAIL blink_off EN=%b want 0", EN); end
    ticks(8); cycle();
    n_cmp++; if (EN !== 1'b1) begin n_bad++; $display("FAIL blink_on EN=%b want 1", EN); end
  endtask

  initial begin
    rst = 1'b1; move_tick = 1'b0; hit = 1'b0; direction = 4'b0000;
    x = 10'd0; y = 10'd0;
    test_reset();
    test_move_left();
    test_move_right_up();
    test_opposing();
    test_hit();
    test_dead();
    test_pixel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
